// File: rtl/icache_line_refill.sv
// Instruction-cache line refill engine: fetches one cache line as a burst of
// 32-bit words over a pipelined req/gnt/rvalid bus and returns it with a valid pulse.
module icache_line_refill #(
   parameter  int unsigned ByteOffsetBits = 4,
   localparam int unsigned NrWordsPerLine = 2 ** (ByteOffsetBits - 2),
   localparam int unsigned LineSize       = 32 * NrWordsPerLine
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                line_req_i,
   input  logic [31:0]         line_addr_i,
   output logic                line_valid_o,
   output logic [LineSize-1:0] line_data_o,
   output logic                bus_req_o,
   output logic [31:0]         bus_addr_o,
   input  logic                bus_gnt_i,
   input  logic                bus_rvalid_i,
   input  logic [31:0]         bus_rdata_i
);

   localparam int unsigned     CntW     = $clog2(NrWordsPerLine + 1);
   localparam logic [CntW-1:0] Words    = CntW'(NrWordsPerLine);
   localparam logic [CntW-1:0] LastWord = CntW'(NrWordsPerLine - 1);
   localparam logic [CntW-1:0] One      = CntW'(1);
   localparam logic [31:0]     OffMask  = ~((32'd1 << ByteOffsetBits) - 32'd1);

   typedef enum logic [1:0] {IDLE, FILL, DONE, DRAIN} state_e;

   state_e              r_state, w_state_nxt;
   logic [31:0]         r_base;
   logic [CntW-1:0]     r_issue_cnt, r_recv_cnt;
   logic [LineSize-1:0] r_line_data;
   logic [CntW-1:0]     w_outstanding;
   logic                w_start, w_issue, w_recv;

   always_comb begin
      w_state_nxt   = r_state;
      bus_req_o     = 1'b0;
      bus_addr_o    = '0;
      line_valid_o  = 1'b0;
      w_start       = 1'b0;
      w_issue       = 1'b0;
      w_recv        = 1'b0;
      w_outstanding = r_issue_cnt - r_recv_cnt;
      unique case (r_state)
         IDLE: begin
            if (line_req_i) begin
               w_start     = 1'b1;
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            if (r_issue_cnt < Words) begin
               bus_req_o  = 1'b1;
               bus_addr_o = r_base + {{(30-CntW){1'b0}}, r_issue_cnt, 2'b00};
            end
            w_issue = bus_req_o && bus_gnt_i;
            w_recv  = bus_rvalid_i && (r_recv_cnt < Words);
            // A line completing on the same edge as the request drop is still delivered.
            if (w_recv && (r_recv_cnt == LastWord)) begin
               w_state_nxt = DONE;
            end else if (!line_req_i) begin
               w_state_nxt = DRAIN;
            end
         end
         DONE: begin
            line_valid_o = 1'b1;
            w_state_nxt  = IDLE;
         end
         DRAIN: begin
            w_recv = bus_rvalid_i && (w_outstanding != '0);
            if ((w_outstanding == '0) || (w_recv && (w_outstanding == One))) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_base      <= '0;
         r_issue_cnt <= '0;
         r_recv_cnt  <= '0;
         r_line_data <= '0;
      end else begin
         if (w_start) begin
            r_base      <= line_addr_i & OffMask;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
         end else begin
            if (w_issue) r_issue_cnt <= r_issue_cnt + One;
            if (w_recv)  r_recv_cnt  <= r_recv_cnt + One;
         end
         // Words drained after an abort are discarded, not written into the line.
         if (w_recv && (r_state == FILL)) begin
            for (int unsigned k = 0; k < NrWordsPerLine; k++) begin
               if (r_recv_cnt == CntW'(k)) r_line_data[32*k +: 32] <= bus_rdata_i;
            end
         end
      end
   end

   assign line_data_o = r_line_data;

endmodule

// File: tb/tb_icache_line_refill.sv
// Directed bench for icache_line_refill: a bus slave model answers requests from a
// word-per-address memory image; completed lines are checked against a scoreboard.
module tb_icache_line_refill;

   localparam int unsigned N  = 4;
   localparam int unsigned LS = 32 * N;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic          line_req_i;
   logic [31:0]   line_addr_i;
   logic          line_valid_o;
   logic [LS-1:0] line_data_o;
   logic          bus_req_o;
   logic [31:0]   bus_addr_o;
   logic          bus_gnt_i;
   logic          bus_rvalid_i;
   logic [31:0]   bus_rdata_i;

   icache_line_refill #(.ByteOffsetBits(4)) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .line_req_i   (line_req_i),
      .line_addr_i  (line_addr_i),
      .line_valid_o (line_valid_o),
      .line_data_o  (line_data_o),
      .bus_req_o    (bus_req_o),
      .bus_addr_o   (bus_addr_o),
      .bus_gnt_i    (bus_gnt_i),
      .bus_rvalid_i (bus_rvalid_i),
      .bus_rdata_i  (bus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          due;
      logic [31:0] data;
   } resp_t;

   int            n_chk = 0;
   int            n_fail = 0;
   int            cyc = 0;
   resp_t         pend[$];
   logic [31:0]   exp_addr[$];
   logic [LS-1:0] sb[$];
   int            lat = 1;
   int            stall_word = -1;
   int            stall_left = 0;
   int            max_grants = 1000;
   int            hs_cnt = 0;
   int            max_out = 0;
   int            valid_cnt = 0;
   int            valid_cyc = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
   endfunction

   function automatic logic [LS-1:0] exp_line(input logic [31:0] addr);
      logic [LS-1:0] l;
      logic [31:0]   base;
      base = {addr[31:4], 4'h0};
      for (int k = 0; k < N; k++) l[32*k +: 32] = mem_word(base + 32'(4 * k));
      return l;
   endfunction

   task automatic chk(input string tag, input logic [LS-1:0] obs, input logic [LS-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // Bus slave: grants, records handshakes, returns data lat cycles after each grant.
   initial forever begin
      @(negedge clk_i);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         bus_rvalid_i = rstn_i;
         bus_rdata_i  = pend[0].data;
         void'(pend.pop_front());
      end else begin
         bus_rvalid_i = 1'b0;
         bus_rdata_i  = $urandom;
      end
      bus_gnt_i = rstn_i;
      if (hs_cnt >= max_grants) begin
         bus_gnt_i = 1'b0;
      end else if (bus_req_o && hs_cnt == stall_word && stall_left > 0) begin
         bus_gnt_i = 1'b0;
         stall_left--;
         if (exp_addr.size() > 0) chk("addr_held", LS'(bus_addr_o), LS'(exp_addr[0]));
      end
      if (rstn_i && bus_req_o && bus_gnt_i) begin
         if (exp_addr.size() == 0) chk("unexpected_req", LS'(bus_req_o), '0);
         else chk("bus_addr", LS'(bus_addr_o), LS'(exp_addr.pop_front()));
         pend.push_back('{due: cyc + lat, data: mem_word(bus_addr_o)});
         hs_cnt++;
         if (pend.size() > max_out) max_out = pend.size();
      end
   end

   // Cache side: drop the request on the valid pulse and score the returned line.
   initial forever begin
      @(negedge clk_i);
      if (line_valid_o) begin
         valid_cnt++;
         valid_cyc  = cyc;
         line_req_i = 1'b0;
         if (sb.size() == 0) chk("unexpected_valid", LS'(line_valid_o), '0);
         else chk("line_data", line_data_o, sb.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic run_line(input logic [31:0] addr, input int l, input int sw, input int sc,
                           input logic [31:0] alt_addr, output int lat_cycles);
      int v0, start;
      lat = l; stall_word = sw; stall_left = sc; max_grants = 1000; hs_cnt = 0; max_out = 0;
      for (int k = 0; k < N; k++) exp_addr.push_back({addr[31:4], 4'h0} + 32'(4 * k));
      sb.push_back(exp_line(addr));
      v0 = valid_cnt;
      tick();
      start = cyc;
      line_req_i  = 1'b1;
      line_addr_i = addr;
      for (int i = 0; i < 300 && valid_cnt == v0; i++) begin
         tick();
         if (cyc == start + 2) line_addr_i = alt_addr;
      end
      line_req_i = 1'b0;
      chk("valid_seen", LS'(valid_cnt), LS'(v0 + 1));
      lat_cycles = valid_cyc - start;
      repeat (3) tick();
      chk("one_pulse", LS'(valid_cnt), LS'(v0 + 1));
      chk("all_words_issued", LS'(exp_addr.size()), '0);
      exp_addr.delete();
      sb.delete();
   endtask

   initial begin
      int lc, v0;
      rstn_i = 1'b0; line_req_i = 1'b0; line_addr_i = '0;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
      repeat (3) tick();
      chk("rst_valid", LS'(line_valid_o), '0);
      chk("rst_req", LS'(bus_req_o), '0);
      chk("rst_addr", LS'(bus_addr_o), '0);
      chk("rst_data", line_data_o, '0);
      rstn_i = 1'b1;
      tick();

      run_line(32'h0000_1234, 1, -1, 0, 32'h0000_1234, lc);
      chk("basic_latency", LS'(lc), LS'(6));

      run_line(32'h0000_1234, 1, 1, 3, 32'h0000_1234, lc);
      chk("stall_latency", LS'(lc), LS'(9));

      run_line(32'h0000_ABC8, 2, -1, 0, 32'h0000_ABC8, lc);
      chk("max_outstanding", LS'(max_out), LS'(2));

      // Abort after two grants; responses arrive only once DRAIN is entered.
      lat = 4; stall_word = -1; max_grants = 2; hs_cnt = 0;
      exp_addr.push_back(32'h0000_3000);
      exp_addr.push_back(32'h0000_3004);
      v0 = valid_cnt;
      tick();
      line_req_i = 1'b1; line_addr_i = 32'h0000_3008;
      for (int i = 0; i < 50 && hs_cnt < 2; i++) tick();
      line_req_i = 1'b0;
      chk("abort_grants", LS'(hs_cnt), LS'(2));
      for (int i = 0; i < 50 && pend.size() > 0; i++) tick();
      repeat (3) tick();
      chk("abort_no_valid", LS'(valid_cnt), LS'(v0));
      chk("abort_req_idle", LS'(bus_req_o), '0);
      max_grants = 1000;
      run_line(32'h0000_2000, 1, -1, 0, 32'h0000_2000, lc);

      run_line(32'h0000_1000, 1, -1, 0, 32'h0000_5000, lc);

      // Reset mid-fill with responses still in flight.
      lat = 2; stall_word = -1; max_grants = 1000; hs_cnt = 0;
      for (int k = 0; k < N; k++) exp_addr.push_back(32'h0000_4000 + 32'(4 * k));
      sb.push_back(exp_line(32'h0000_4000));
      v0 = valid_cnt;
      tick();
      line_req_i = 1'b1; line_addr_i = 32'h0000_4000;
      for (int i = 0; i < 50 && hs_cnt < 2; i++) tick();
      rstn_i = 1'b0; line_req_i = 1'b0;
      #1;
      chk("midrst_req", LS'(bus_req_o), '0);
      chk("midrst_addr", LS'(bus_addr_o), '0);
      chk("midrst_data", line_data_o, '0);
      chk("midrst_valid", LS'(line_valid_o), '0);
      sb.delete();
      exp_addr.delete();
      tick();
      rstn_i = 1'b1;
      for (int i = 0; i < 50 && pend.size() > 0; i++) tick();
      repeat (2) tick();
      chk("stray_rvalid_data", line_data_o, '0);
      chk("stray_rvalid_req", LS'(bus_req_o), '0);
      chk("stray_rvalid_valid", LS'(valid_cnt), LS'(v0));
      run_line(32'h0000_6004, 1, -1, 0, 32'h0000_6004, lc);
      chk("post_rst_latency", LS'(lc), LS'(6));

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
